uart_rx_framer: RTL and testbench
=================================

UART_RX_FRAMER -- requirements
Module: uart_rx_framer

Interface
REQ-001 SHALL have parameter SYNC_DEPTH, default 2: number of RX metastability flip-flops, legal range 2..4.
REQ-002 SHALL have port CLK, input, 1 bit: single system clock; all flops are rising-edge.
REQ-003 SHALL have port RESET, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port BAUD_TICK, input, 1 bit: one-CLK-wide enable at 16x the bit rate, driven by the baud clock generator.
REQ-005 SHALL have port RX, input, 1 bit: asynchronous serial line, idle high.
REQ-006 SHALL have port BIT8, input, 1 bit: 1 means 8 data bits, 0 means 7 data bits.
REQ-007 SHALL have port PARITY_EN, input, 1 bit: 1 means a parity bit follows the data bits.
REQ-008 SHALL have port ODD_N_EVEN, input, 1 bit: 1 means odd parity, 0 means even parity.
REQ-009 SHALL have port RD, input, 1 bit: one-CLK read strobe that acknowledges the held character.
REQ-010 SHALL have port RX_DATA, output, 8 bits: last received character, LSB first on the line.
REQ-011 SHALL have port RX_VALID, output, 1 bit: a character is held and not yet read.
REQ-012 SHALL have port PARITY_ERR, output, 1 bit: parity mismatch on the held character.
REQ-013 SHALL have port FRAMING_ERR, output, 1 bit: the stop bit of the held character sampled low.
REQ-014 SHALL have port OVERFLOW, output, 1 bit: sticky flag; a character completed while RX_VALID=1 and was dropped.

Function
REQ-015 SHALL pass RX through SYNC_DEPTH flops; the sync chain resets to 1, and all decisions use the synchronized value rxs.
REQ-016 SHALL implement states IDLE, START, DATA, PARITY, STOP, BRKWAIT, with a 4-bit tick counter cnt (0..15) and a 3-bit bit index.
REQ-017 SHALL advance cnt, and evaluate rxs, only on CLK edges where BAUD_TICK=1; other cycles hold all state.
REQ-018 IDLE: on a tick with rxs=0, SHALL enter START with cnt=0; otherwise stay in IDLE.
REQ-019 Each bit window SHALL span cnt 0..15, with rxs sampled at cnt 7, 8 and 9 and the bit value taken as the 2-of-3 majority at cnt 9.
REQ-020 START: a majority of 1 SHALL return to IDLE (false start, no flags); a majority of 0 SHALL continue and enter DATA at cnt wrap 15->0 with index 0.
REQ-021 DATA: SHALL shift the majority bit into the shift register LSB first; after bit 7 (BIT8=1) or bit 6 (BIT8=0) it SHALL go to PARITY if PARITY_EN=1, else to STOP.
REQ-022 PARITY: SHALL compute err = XOR(data bits, parity bit) XOR ODD_N_EVEN, which must be 0 for a pass; err is latched with the character.
REQ-023 STOP: at cnt 9 SHALL complete the character, go to IDLE if the majority is 1, and go to BRKWAIT if it is 0.
REQ-024 BRKWAIT: SHALL return to IDLE on the first tick with rxs=1, so that no start is detected during a break.
REQ-025 On completion with RX_VALID=0 or RD=1 in the same cycle, the block SHALL load RX_DATA (bit 7 forced to 0 when BIT8=0), PARITY_ERR (0 if PARITY_EN=0) and FRAMING_ERR, and set RX_VALID, all registered one CLK after the completing tick.
REQ-026 On completion with RX_VALID=1 and RD=0, SHALL leave RX_DATA and the error flags unchanged and set OVERFLOW.
REQ-027 RD with no completion SHALL clear RX_VALID, PARITY_ERR, FRAMING_ERR and OVERFLOW on the next CLK edge.
REQ-028 RD with a simultaneous completion SHALL load the new character, keep RX_VALID=1 and clear OVERFLOW.
REQ-029 RD while RX_VALID=0 SHALL have no effect.
REQ-030 BIT8, PARITY_EN and ODD_N_EVEN SHALL be treated as static during a frame; changes mid-frame give an undefined character but SHALL NOT lock up the FSM.
REQ-031 Frame latency SHALL be from the START entry tick to RX_VALID = (1 start + N data + P parity) x 16 + 10 ticks, plus 1 CLK.

Reset
REQ-032 RESET=1 SHALL asynchronously force IDLE, cnt=0, index=0, shift register=0, RX_DATA=0x00, and RX_VALID=PARITY_ERR=FRAMING_ERR=OVERFLOW=0.
REQ-033 Reset asserted mid-frame SHALL discard the partial character; after release, reception SHALL resume at the next start bit (sync chain reset high, so no false start).

Verification
REQ-034 8N1, byte 0xA5, 16 ticks/bit -> RX_DATA=0xA5, RX_VALID=1 at 9x16+10 ticks after START entry, PARITY_ERR=FRAMING_ERR=0.
REQ-035 7E1, 0x41 sent with parity bit 1 -> RX_DATA=0x41, PARITY_ERR=1; the same frame with parity bit 0 -> PARITY_ERR=0; 7O1 with parity bit 1 -> PARITY_ERR=0.
REQ-036 A low pulse of 5 ticks on idle RX -> FSM returns to IDLE, RX_VALID stays 0; a single-tick glitch at cnt 8 of a data bit -> majority ignores it and the byte is correct.
REQ-037 8N1 0x3C with the stop bit held low for 40 ticks, then high -> FRAMING_ERR=1, no start detected until rxs=1; the next frame 0x55 is received correctly after RD.
REQ-038 Two frames, 0x11 then 0x22, with no RD -> RX_DATA=0x11, OVERFLOW=1; RD pulsed on the second completion cycle -> RX_DATA=0x22, OVERFLOW=0, RX_VALID=1.
REQ-039 RESET asserted at data bit 4 of 0xFF, then released, then 0x0F sent -> outputs 0 during reset, then RX_DATA=0x0F with no error flags.

Source files
------------

// File: rtl/uart_rx_framer.sv
// UART receive framer: 16x oversampled start/data/parity/stop recovery with
// 2-of-3 majority voting, a single-character holding register and status flags.
module uart_rx_framer #(
  parameter int SYNC_DEPTH = 2
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       BAUD_TICK,
  input  logic       RX,
  input  logic       BIT8,
  input  logic       PARITY_EN,
  input  logic       ODD_N_EVEN,
  input  logic       RD,
  output logic [7:0] RX_DATA,
  output logic       RX_VALID,
  output logic       PARITY_ERR,
  output logic       FRAMING_ERR,
  output logic       OVERFLOW
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    PARITY  = 3'd3,
    STOP    = 3'd4,
    BRKWAIT = 3'd5
  } state_t;

  // Seven-bit characters sit in shift[7:1] because bits enter at the MSB.
  function automatic logic data_parity(input logic [7:0] sh, input logic bit8);
    logic [7:0] bits;
    if (bit8) begin
      bits = sh;
    end else begin
      bits = {1'b0, sh[7:1]};
    end
    return ^bits;
  endfunction

  logic [SYNC_DEPTH-1:0] sync_q, sync_d;
  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [2:0]            idx_q, idx_d;
  logic [7:0]            shift_q, shift_d;
  logic                  s7_q, s7_d, s8_q, s8_d;
  logic                  perr_q, perr_d;
  logic                  done_q, done_d;
  logic [7:0]            cap_data_q, cap_data_d;
  logic                  cap_perr_q, cap_perr_d;
  logic                  cap_ferr_q, cap_ferr_d;
  logic [7:0]            rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  parity_err_q, parity_err_d;
  logic                  framing_err_q, framing_err_d;
  logic                  overflow_q, overflow_d;

  logic       rxs;
  logic       maj;
  logic [2:0] last_idx;

  assign rxs      = sync_q[SYNC_DEPTH-1];
  assign maj      = (s7_q & s8_q) | (s7_q & rxs) | (s8_q & rxs);
  assign last_idx = BIT8 ? 3'd7 : 3'd6;

  always_comb begin
    sync_d = {sync_q[SYNC_DEPTH-2:0], RX};
  end

  // Bit-window sequencing; everything advances only on baud ticks.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    s7_d       = s7_q;
    s8_d       = s8_q;
    perr_d     = perr_q;
    done_d     = 1'b0;
    cap_data_d = cap_data_q;
    cap_perr_d = cap_perr_q;
    cap_ferr_d = cap_ferr_q;
    if (BAUD_TICK) begin
      cnt_d = cnt_q + 4'd1;
      if (cnt_q == 4'd7) begin
        s7_d = rxs;
      end else begin
        s7_d = s7_q;
      end
      if (cnt_q == 4'd8) begin
        s8_d = rxs;
      end else begin
        s8_d = s8_q;
      end
      case (state_q)
        IDLE: begin
          cnt_d = 4'd0;
          if (!rxs) begin
            state_d = START;
            idx_d   = 3'd0;
            shift_d = 8'h00;
            perr_d  = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
        START: begin
          if ((cnt_q == 4'd9) && maj) begin
            state_d = IDLE;
            cnt_d   = 4'd0;
          end else if (cnt_q == 4'd15) begin
            state_d = DATA;
            idx_d   = 3'd0;
          end else begin
            state_d = START;
          end
        end
        DATA: begin
          if (cnt_q == 4'd9) begin
            shift_d = {maj, shift_q[7:1]};
          end else begin
            shift_d = shift_q;
          end
          // >= so a mid-frame BIT8 change cannot run the index past the end.
          if (cnt_q == 4'd15) begin
            if (idx_q >= last_idx) begin
              idx_d   = 3'd0;
              state_d = PARITY_EN ? PARITY : STOP;
            end else begin
              idx_d = idx_q + 3'd1;
            end
          end else begin
            idx_d = idx_q;
          end
        end
        PARITY: begin
          if (cnt_q == 4'd9) begin
            perr_d = data_parity(shift_q, BIT8) ^ maj ^ ODD_N_EVEN;
          end else begin
            perr_d = perr_q;
          end
          if (cnt_q == 4'd15) begin
            state_d = STOP;
          end else begin
            state_d = PARITY;
          end
        end
        STOP: begin
          if (cnt_q == 4'd9) begin
            done_d     = 1'b1;
            cap_data_d = BIT8 ? shift_q : {1'b0, shift_q[7:1]};
            cap_perr_d = PARITY_EN & perr_q;
            cap_ferr_d = ~maj;
            cnt_d      = 4'd0;
            state_d    = maj ? IDLE : BRKWAIT;
          end else begin
            state_d = STOP;
          end
        end
        BRKWAIT: begin
          cnt_d = 4'd0;
          if (rxs) begin
            state_d = IDLE;
          end else begin
            state_d = BRKWAIT;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = 4'd0;
          idx_d   = 3'd0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Holding register: a completed character lands one CLK after its tick.
  always_comb begin
    rx_data_d     = rx_data_q;
    rx_valid_d    = rx_valid_q;
    parity_err_d  = parity_err_q;
    framing_err_d = framing_err_q;
    overflow_d    = overflow_q;
    if (done_q) begin
      if (!rx_valid_q || RD) begin
        rx_data_d     = cap_data_q;
        parity_err_d  = cap_perr_q;
        framing_err_d = cap_ferr_q;
        rx_valid_d    = 1'b1;
        overflow_d    = RD ? 1'b0 : overflow_q;
      end else begin
        overflow_d = 1'b1;
      end
    end else if (RD && rx_valid_q) begin
      rx_valid_d    = 1'b0;
      parity_err_d  = 1'b0;
      framing_err_d = 1'b0;
      overflow_d    = 1'b0;
    end else begin
      rx_valid_d = rx_valid_q;
    end
  end

  // Sync chain resets high so a reset release never looks like a start bit.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sync_q        <= {SYNC_DEPTH{1'b1}};
      state_q       <= IDLE;
      cnt_q         <= 4'd0;
      idx_q         <= 3'd0;
      shift_q       <= 8'h00;
      s7_q          <= 1'b1;
      s8_q          <= 1'b1;
      perr_q        <= 1'b0;
      done_q        <= 1'b0;
      cap_data_q    <= 8'h00;
      cap_perr_q    <= 1'b0;
      cap_ferr_q    <= 1'b0;
      rx_data_q     <= 8'h00;
      rx_valid_q    <= 1'b0;
      parity_err_q  <= 1'b0;
      framing_err_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      sync_q        <= sync_d;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      shift_q       <= shift_d;
      s7_q          <= s7_d;
      s8_q          <= s8_d;
      perr_q        <= perr_d;
      done_q        <= done_d;
      cap_data_q    <= cap_data_d;
      cap_perr_q    <= cap_perr_d;
      cap_ferr_q    <= cap_ferr_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      parity_err_q  <= parity_err_d;
      framing_err_q <= framing_err_d;
      overflow_q    <= overflow_d;
    end
  end

  assign RX_DATA     = rx_data_q;
  assign RX_VALID    = rx_valid_q;
  assign PARITY_ERR  = parity_err_q;
  assign FRAMING_ERR = framing_err_q;
  assign OVERFLOW    = overflow_q;

endmodule

// File: tb/tb_uart_rx_framer.sv
// Bench for uart_rx_framer: table-driven frames, hand-built corner sequences
// and randomized frames checked against a frame-level reference model.
module tb_uart_rx_framer;

  localparam int PRE  = 2;
  localparam int POST = 4;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       BAUD_TICK;
  logic       RX;
  logic       BIT8;
  logic       PARITY_EN;
  logic       ODD_N_EVEN;
  logic       RD;
  logic [7:0] RX_DATA;
  logic       RX_VALID;
  logic       PARITY_ERR;
  logic       FRAMING_ERR;
  logic       OVERFLOW;

  int n_cmp = 0;
  int n_err = 0;

  uart_rx_framer #(.SYNC_DEPTH(2)) dut (
    .CLK(CLK), .RESET(RESET), .BAUD_TICK(BAUD_TICK), .RX(RX), .BIT8(BIT8),
    .PARITY_EN(PARITY_EN), .ODD_N_EVEN(ODD_N_EVEN), .RD(RD), .RX_DATA(RX_DATA),
    .RX_VALID(RX_VALID), .PARITY_ERR(PARITY_ERR), .FRAMING_ERR(FRAMING_ERR),
    .OVERFLOW(OVERFLOW)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [7:0] data;
    logic       bit8;
    logic       pen;
    logic       odd;
    logic       pbit;
    logic [7:0] stop_low;
    logic [7:0] exp_data;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs [8];

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0b required %0b", nm, act, exp);
    end
  endtask

  task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %02h required %02h", nm, act, exp);
    end
  endtask

  task automatic check_held(input string tag, input logic [7:0] d, input logic v,
                            input logic pe, input logic fe, input logic ov);
    chk8({tag, "_data"}, RX_DATA, d);
    chk1({tag, "_valid"}, RX_VALID, v);
    chk1({tag, "_perr"}, PARITY_ERR, pe);
    chk1({tag, "_ferr"}, FRAMING_ERR, fe);
    chk1({tag, "_ovf"}, OVERFLOW, ov);
  endtask

  // One baud tick; the framer sees v on this tick (sync settles in the gap).
  task automatic do_tick(input logic v);
    RX = v;
    BAUD_TICK = 1'b0;
    repeat (3) @(negedge CLK);
    BAUD_TICK = 1'b1;
    @(negedge CLK);
    BAUD_TICK = 1'b0;
  endtask

  task automatic rd_pulse();
    RD = 1'b1;
    @(negedge CLK);
    RD = 1'b0;
  endtask

  // Reference model: what the held character should be for a given frame.
  function automatic logic [7:0] model_data(input logic [7:0] d, input logic bit8);
    return bit8 ? d : {1'b0, d[6:0]};
  endfunction

  function automatic logic model_perr(input logic [7:0] d, input logic bit8, input logic pen,
                                      input logic odd, input logic pbit);
    logic [7:0] md;
    int ones;
    md = model_data(d, bit8);
    ones = 0;
    for (int k = 0; k < 8; k++) ones += int'(md[k]);
    if (!pen) return 1'b0;
    return ((ones + int'(pbit)) % 2 == 1) != odd;
  endfunction

  // Sends a whole line waveform; rst_at/glitch_win < 0 disable those features.
  task automatic send_frame(input logic [7:0] data, input logic bit8, input logic pen,
                            input logic odd, input logic pbit, input int stop_low,
                            input int glitch_win, input int rst_at,
                            input logic rd_at_done, input logic chk_lat);
    logic line[$];
    int nd, done_idx;
    nd = bit8 ? 8 : 7;
    BIT8 = bit8;
    PARITY_EN = pen;
    ODD_N_EVEN = odd;
    repeat (PRE) line.push_back(1'b1);
    repeat (16) line.push_back(1'b0);
    for (int b = 0; b < nd; b++) repeat (16) line.push_back(data[b]);
    if (pen) repeat (16) line.push_back(pbit);
    repeat (stop_low) line.push_back(1'b0);
    repeat (16 + POST) line.push_back(1'b1);
    done_idx = PRE + 16 * (1 + nd + (pen ? 1 : 0)) + 10;
    if (glitch_win >= 0) line[PRE + 16 * glitch_win + 9] = ~line[PRE + 16 * glitch_win + 9];
    for (int i = 0; i < line.size(); i++) begin
      do_tick(line[i]);
      if (i == done_idx && (rd_at_done || chk_lat)) begin
        if (rd_at_done) RD = 1'b1;
        if (chk_lat) chk1("lat_before", RX_VALID, 1'b0);
        @(negedge CLK);
        RD = 1'b0;
        if (chk_lat) chk1("lat_after", RX_VALID, 1'b1);
      end
      if (rst_at >= 0 && i == PRE + rst_at) begin
        RESET = 1'b1;
        #1;
        check_held("in_rst", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge CLK);
        RESET = 1'b0;
      end
    end
  endtask

  initial begin
    logic [7:0] rd8;
    logic rb8, rpen, rodd, rpb;
    int rstop;

    RESET = 1'b1; RX = 1'b1; BAUD_TICK = 1'b0; RD = 1'b0;
    BIT8 = 1'b1; PARITY_EN = 1'b0; ODD_N_EVEN = 1'b0;
    repeat (3) @(negedge CLK);
    check_held("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    RESET = 1'b0;
    repeat (2) @(negedge CLK);
    rd_pulse();
    check_held("rd_idle", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

    //            data   b8    pen   odd   pbit  stoplo exp    perr  ferr
    vecs[0] = '{8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0,  8'hA5, 1'b0, 1'b0};
    vecs[1] = '{8'h41, 1'b0, 1'b1, 1'b0, 1'b1, 8'd0,  8'h41, 1'b1, 1'b0};
    vecs[2] = '{8'h41, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0,  8'h41, 1'b0, 1'b0};
    vecs[3] = '{8'h41, 1'b0, 1'b1, 1'b1, 1'b1, 8'd0,  8'h41, 1'b0, 1'b0};
    vecs[4] = '{8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0,  8'h7F, 1'b0, 1'b0};
    vecs[5] = '{8'h80, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0,  8'h80, 1'b0, 1'b0};
    vecs[6] = '{8'h3C, 1'b1, 1'b1, 1'b0, 1'b1, 8'd0,  8'h3C, 1'b1, 1'b0};
    vecs[7] = '{8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'd16, 8'h00, 1'b0, 1'b1};
    for (int v = 0; v < 8; v++) begin
      send_frame(vecs[v].data, vecs[v].bit8, vecs[v].pen, vecs[v].odd, vecs[v].pbit,
                 int'(vecs[v].stop_low), -1, -1, 1'b0, 1'b1);
      check_held($sformatf("vec%0d", v), vecs[v].exp_data, 1'b1, vecs[v].exp_perr,
                 vecs[v].exp_ferr, 1'b0);
      rd_pulse();
      check_held($sformatf("vec%0d_rd", v), vecs[v].exp_data, 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // Five-tick low pulse is a false start.
    BIT8 = 1'b1; PARITY_EN = 1'b0;
    repeat (2) do_tick(1'b1);
    repeat (5) do_tick(1'b0);
    repeat (24) do_tick(1'b1);
    chk1("false_start_valid", RX_VALID, 1'b0);

    // Single-tick glitch at cnt 8 of data bit 3 is outvoted.
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 0, 4, -1, 1'b0, 1'b1);
    check_held("glitch", 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
    rd_pulse();

    // Break: stop held low 40 ticks; no character may be seen inside it.
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 40, -1, -1, 1'b0, 1'b1);
    check_held("break", 8'h3C, 1'b1, 1'b0, 1'b1, 1'b0);
    rd_pulse();
    send_frame(8'h55, 1'b1, 1'b0, 1'b0, 1'b0, 0, -1, -1, 1'b0, 1'b1);
    check_held("after_break", 8'h55, 1'b1, 1'b0, 1'b0, 1'b0);
    rd_pulse();

    // Overflow without a read, then read clears everything.
    send_frame(8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 0, -1, -1, 1'b0, 1'b1);
    send_frame(8'h22, 1'b1, 1'b0, 1'b0, 1'b0, 0, -1, -1, 1'b0, 1'b0);
    check_held("ovf", 8'h11, 1'b1, 1'b0, 1'b0, 1'b1);
    rd_pulse();
    check_held("ovf_rd", 8'h11, 1'b0, 1'b0, 1'b0, 1'b0);

    // Read coinciding with the second completion loads the new character.
    send_frame(8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 0, -1, -1, 1'b0, 1'b1);
    send_frame(8'h22, 1'b1, 1'b0, 1'b0, 1'b0, 0, -1, -1, 1'b1, 1'b0);
    check_held("rd_at_done", 8'h22, 1'b1, 1'b0, 1'b0, 1'b0);
    rd_pulse();

    // Reset during data bit 4 of 0xFF while a character is held.
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 0, -1, -1, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 0, -1, 16 * 5 + 4, 1'b0, 1'b0);
    check_held("post_rst", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h0F, 1'b1, 1'b0, 1'b0, 1'b0, 0, -1, -1, 1'b0, 1'b1);
    check_held("rst_recover", 8'h0F, 1'b1, 1'b0, 1'b0, 1'b0);
    rd_pulse();

    // Randomized frames against the reference model.
    for (int r = 0; r < 16; r++) begin
      rd8   = 8'($urandom);
      rb8   = 1'($urandom_range(0, 1));
      rpen  = 1'($urandom_range(0, 1));
      rodd  = 1'($urandom_range(0, 1));
      rpb   = 1'($urandom_range(0, 1));
      rstop = ($urandom_range(0, 3) == 0) ? int'($urandom_range(11, 30)) : 0;
      send_frame(rd8, rb8, rpen, rodd, rpb, rstop, -1, -1, 1'b0, 1'b1);
      check_held($sformatf("rnd%0d", r), model_data(rd8, rb8), 1'b1,
                 model_perr(rd8, rb8, rpen, rodd, rpb), rstop != 0, 1'b0);
      rd_pulse();
      chk1($sformatf("rnd%0d_rd_valid", r), RX_VALID, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
